// File: rtl/ppm_pkg.sv
// Shared types and helpers for the PPM transmit arbiter.
// Holds the arbiter FSM state enum and the watchdog limit formula.
// No ports; imported by ppm_tx_arbiter and rr_pick users.
package ppm_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_t;

    // Default link parameters of the PPM encoder/decoder pair.
    localparam int DEF_N_MOD   = 2;
    localparam int DEF_L       = 20;
    localparam int DEF_PRE_CT  = 15;
    localparam int DEF_N_PKT   = 8;
    localparam int DEF_HISTORY = 4;

    // Worst-case encoder handshake length: every symbol slot of the preamble
    // and payload, plus decoder history settling.
    function automatic int ppm_timeout(input int n_mod, input int l, input int pre_ct,
                                       input int n_pkt, input int hist);
        return ((1 << n_mod) * l) * (pre_ct + n_pkt / n_mod) + 5 * hist;
    endfunction

    localparam int DEF_TIMEOUT = ppm_timeout(DEF_N_MOD, DEF_L, DEF_PRE_CT,
                                             DEF_N_PKT, DEF_HISTORY);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above ptr, wrapping.
// Ports: req [NREQ] request vector, ptr starting index; any = some bit set,
// idx = chosen index (0 when none set).
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            any,
    output logic [IW-1:0]   idx
);

    // Walk offsets from highest to lowest so the smallest offset from ptr
    // is the last assignment and therefore wins.
    always_comb begin
        int j;
        any = 1'b0;
        idx = '0;
        j   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (req[j]) begin
                any = 1'b1;
                idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/ppm_tx_arbiter.sv
// Round-robin arbiter sharing one PPM Encoder between NREQ transmit requesters.
// Ports: req_valid/req_data in, req_ack/req_done/req_fault one-cycle pulses out;
// enc_start/enc_data to the Encoder, enc_avail from it; busy and grant_id status.
module ppm_tx_arbiter
    import ppm_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int N_PKT   = 8,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*N_PKT-1:0]    req_data,
    output logic [NREQ-1:0]          req_ack,
    output logic [NREQ-1:0]          req_done,
    output logic [NREQ-1:0]          req_fault,
    output logic                     enc_start,
    output logic [N_PKT-1:0]         enc_data,
    input  logic                     enc_avail,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  grant_id
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    arb_state_t          state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       grant_q, grant_d;
    logic [N_PKT-1:0]    data_q, data_d;
    logic [NREQ-1:0]     ack_q, ack_d;
    logic [NREQ-1:0]     done_q, done_d;
    logic [NREQ-1:0]     fault_q, fault_d;
    logic                start_q, start_d;

    logic                pick_any;
    logic [IW-1:0]       pick_idx;
    logic [IW-1:0]       ptr_next;
    logic [TW-1:0]       timer_inc;
    logic                expired;
    logic [NREQ-1:0]     grant_sel;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req  (req_valid),
        .ptr  (ptr_q),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // Next requester after the one just served gets first look.
    assign ptr_next  = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + IW'(1);
    // Saturating count so a stalled handshake can never wrap back below the limit.
    assign timer_inc = (timer_q == TW'(TIMEOUT)) ? timer_q : timer_q + TW'(1);
    assign expired   = (timer_q == TW'(TIMEOUT - 1));
    assign grant_sel = NREQ'(1) << grant_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        data_d  = data_q;
        ack_d   = '0;
        done_d  = '0;
        fault_d = '0;
        start_d = 1'b0;
        case (state_q)
            IDLE: begin
                // Requests stay pending while the encoder is not ready.
                if (enc_avail && pick_any) begin
                    state_d = WAIT_BUSY;
                    grant_d = pick_idx;
                    data_d  = req_data[int'(pick_idx) * N_PKT +: N_PKT];
                    ack_d   = NREQ'(1) << pick_idx;
                    start_d = 1'b1;
                    timer_d = '0;
                end
            end
            WAIT_BUSY: begin
                if (!enc_avail) begin
                    state_d = WAIT_DONE;
                    timer_d = '0;
                end else if (expired) begin
                    state_d = IDLE;
                    fault_d = grant_sel;
                    ptr_d   = ptr_next;
                end else begin
                    timer_d = timer_inc;
                end
            end
            WAIT_DONE: begin
                if (enc_avail) begin
                    state_d = IDLE;
                    done_d  = grant_sel;
                    ptr_d   = ptr_next;
                end else if (expired) begin
                    state_d = IDLE;
                    fault_d = grant_sel;
                    ptr_d   = ptr_next;
                end else begin
                    timer_d = timer_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            data_q  <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            fault_q <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            start_q <= start_d;
        end
    end

    assign req_ack   = ack_q;
    assign req_done  = done_q;
    assign req_fault = fault_q;
    assign enc_start = start_q;
    assign enc_data  = data_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ppm_tx_arbiter.sv
// Directed bench for ppm_tx_arbiter with a behavioural encoder stub.
// Ports: none; drives the DUT and logs every start/ack/done/fault pulse.
// Modes of the stub: 0 normal handshake, 1 avail stuck high, 2 avail stuck low, 3 manual.
module tb_ppm_tx_arbiter;
    import ppm_pkg::*;

    localparam int NREQ    = 2;
    localparam int N_PKT   = 8;
    localparam int TIMEOUT = DEF_TIMEOUT;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*N_PKT-1:0] req_data;
    logic [NREQ-1:0]     req_ack, req_done, req_fault;
    logic                enc_start;
    logic [N_PKT-1:0]    enc_data;
    logic                enc_avail;
    logic                busy;
    logic [0:0]          grant_id;

    ppm_tx_arbiter #(.NREQ(NREQ), .N_PKT(N_PKT), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .req_done  (req_done),
        .req_fault (req_fault),
        .enc_start (enc_start),
        .enc_data  (enc_data),
        .enc_avail (enc_avail),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Event logs, sampled on the falling edge.
    int st_cyc[$], st_dat[$], st_gid[$];
    int ak_cyc[$], ak_vec[$];
    int dn_cyc[$], dn_vec[$], dn_busy[$];
    int ft_cyc[$], ft_vec[$], ft_busy[$];
    bit auto_clear = 1'b1;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (enc_start) begin
                st_cyc.push_back(cyc);
                st_dat.push_back(int'(enc_data));
                st_gid.push_back(int'(grant_id));
            end
            if (req_ack != 0) begin
                ak_cyc.push_back(cyc);
                ak_vec.push_back(int'(req_ack));
                check("ack_with_start", {31'd0, enc_start}, 32'd1);
                if (auto_clear) req_valid = req_valid & ~req_ack;
            end
            if (req_done != 0) begin
                dn_cyc.push_back(cyc);
                dn_vec.push_back(int'(req_done));
                dn_busy.push_back(int'(busy));
            end
            if (req_fault != 0) begin
                ft_cyc.push_back(cyc);
                ft_vec.push_back(int'(req_fault));
                ft_busy.push_back(int'(busy));
            end
            if ((req_ack | req_done | req_fault) != 0)
                check("pulse_exclusive",
                      {31'd0, $onehot(req_ack) ^ $onehot(req_done) ^ $onehot(req_fault)
                              && $onehot0(req_ack) && $onehot0(req_done) && $onehot0(req_fault)
                              && (int'(req_ack != 0) + int'(req_done != 0) + int'(req_fault != 0) == 1)},
                      32'd1);
        end
    end

    // Behavioural encoder: reacts to enc_start according to enc_mode.
    int enc_mode = 0;
    int rise_cyc = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (enc_start === 1'b1) begin
                case (enc_mode)
                    0: begin
                        repeat (2) @(negedge clk);
                        enc_avail = 1'b0;
                        repeat (8) @(negedge clk);
                        enc_avail = 1'b1;
                        rise_cyc  = cyc;
                    end
                    2: enc_avail = 1'b0;
                    default: ;
                endcase
            end
        end
    end

    function automatic int qsize(input int which);
        case (which)
            0: return st_cyc.size();
            1: return dn_cyc.size();
            default: return ft_cyc.size();
        endcase
    endfunction

    task automatic wait_q(input string tag, input int which, input int target, input int budget);
        int k;
        k = 0;
        while (qsize(which) < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (qsize(which) < target) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int t0, k_rise, n_ak, n_st;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        enc_avail = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_gid",   {31'd0, grant_id}, 32'd0);
        check("rst_data",  {24'd0, enc_data}, 32'd0);
        check("rst_start", {31'd0, enc_start}, 32'd0);
        check("rst_pulses", {26'd0, req_ack, req_done, req_fault}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single request from requester 0.
        req_data[7:0] = 8'h42;
        req_valid     = 2'b01;
        t0            = cyc;
        wait_q("t1_start", 0, 1, 20);
        check("t1_start_lat", st_cyc[0], t0 + 1);
        check("t1_ack_lat",   ak_cyc[0], t0 + 1);
        check("t1_ack_vec",   ak_vec[0], 1);
        check("t1_data",      st_dat[0], 32'h42);
        check("t1_gid",       st_gid[0], 0);
        wait_q("t1_done", 1, 1, 40);
        check("t1_done_vec",  dn_vec[0], 1);
        check("t1_done_lat",  dn_cyc[0], rise_cyc + 1);
        check("t1_done_busy", dn_busy[0], 0);
        check("t1_nstart",    st_cyc.size(), 1);

        // Simultaneous requests right after reset.
        rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
        req_data  = {8'h8f, 8'h42};
        req_valid = 2'b11;
        wait_q("t2_done", 1, 3, 100);
        check("t2_dat0", st_dat[1], 32'h42);
        check("t2_gid0", st_gid[1], 0);
        check("t2_dat1", st_dat[2], 32'h8f);
        check("t2_gid1", st_gid[2], 1);
        check("t2_ack0", ak_vec[1], 1);
        check("t2_ack1", ak_vec[2], 2);
        check("t2_dn0",  dn_vec[1], 1);
        check("t2_dn1",  dn_vec[2], 2);
        check("t2_nack", ak_vec.size(), 3);
        check("t2_gap",  32'(st_cyc[2] > dn_cyc[1]), 32'd1);

        // Fairness with both requesters held valid.
        auto_clear = 1'b0;
        req_valid  = 2'b11;
        wait_q("t3_start", 0, 9, 150);
        req_valid  = 2'b00;
        auto_clear = 1'b1;
        wait_q("t3_done", 1, 9, 40);
        for (int i = 0; i < 6; i++)
            check($sformatf("t3_gid%0d", i), st_gid[3 + i], i % 2);

        // Watchdog: encoder never drops avail.
        enc_mode      = 1;
        req_data[7:0] = 8'h77;
        req_valid     = 2'b01;
        wait_q("t4_fault", 2, 1, TIMEOUT + 40);
        check("t4_fault_vec",  ft_vec[0], 1);
        check("t4_fault_lat",  ft_cyc[0] - st_cyc[9], TIMEOUT);
        check("t4_fault_busy", ft_busy[0], 0);
        check("t4_no_done",    dn_cyc.size(), 9);

        // Watchdog: encoder drops avail and never returns it.
        enc_mode      = 2;
        req_data[7:0] = 8'h78;
        req_valid     = 2'b01;
        wait_q("t5_fault", 2, 2, TIMEOUT + 40);
        check("t5_fault_vec",  ft_vec[1], 1);
        check("t5_fault_lat",  ft_cyc[1] - st_cyc[10], TIMEOUT + 1);
        check("t5_fault_busy", ft_busy[1], 0);
        check("t5_no_done",    dn_cyc.size(), 9);
        enc_avail = 1'b1;
        enc_mode  = 0;
        @(negedge clk);

        // Reset while waiting for the encoder to finish.
        req_data[7:0] = 8'h5a;
        req_valid     = 2'b01;
        wait_q("t6_start", 0, 12, 20);
        check("t6_data_pre", st_dat[11], 32'h5a);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_busy",   {31'd0, busy}, 32'd0);
        check("t6_data",   {24'd0, enc_data}, 32'd0);
        check("t6_gid",    {31'd0, grant_id}, 32'd0);
        check("t6_pulses", {25'd0, enc_start, req_ack, req_done, req_fault}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("t6_no_done",  dn_cyc.size(), 9);
        check("t6_no_fault", ft_cyc.size(), 2);
        req_data[15:8] = 8'hc3;
        req_valid      = 2'b10;
        wait_q("t6_start1", 0, 13, 20);
        check("t6_gid1",  st_gid[12], 1);
        check("t6_dat1",  st_dat[12], 32'hc3);
        wait_q("t6_done1", 1, 10, 40);
        check("t6_dn1",   dn_vec[9], 2);

        // Encoder not available while idle.
        enc_mode      = 3;
        enc_avail     = 1'b0;
        n_ak          = ak_vec.size();
        n_st          = st_cyc.size();
        req_data[7:0] = 8'h11;
        req_valid     = 2'b01;
        repeat (20) @(negedge clk);
        check("t7_no_ack",   ak_vec.size(), n_ak);
        check("t7_no_start", st_cyc.size(), n_st);
        enc_mode  = 0;
        enc_avail = 1'b1;
        k_rise    = cyc;
        wait_q("t7_start", 0, n_st + 1, 20);
        check("t7_start_lat", st_cyc[n_st], k_rise + 1);
        check("t7_data",      st_dat[n_st], 32'h11);
        wait_q("t7_done", 1, 11, 40);
        check("t7_dn",        dn_vec[10], 1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
